// File: rtl/hack_alu_pkg.sv
// Shared definitions for the Hack ALU and the sequential multiplier built on it.
// Control words are packed in {zx, nx, zy, ny, f, no} order.
package hack_alu_pkg;

    localparam logic [5:0] ALU_X_AND_Y  = 6'b000000;
    localparam logic [5:0] ALU_X_PLUS_Y = 6'b000010;
    localparam logic [5:0] ALU_ZERO     = 6'b101010;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_ADD,
        S_DBL,
        S_DONE
    } mul_state_e;

endpackage

// File: rtl/hack_alu.sv
// 16-bit Hack ALU: optional zero/negate on each input, add or AND, optional
// output negate, plus zero and negative flags.
module hack_alu (
    input  logic [15:0] x_i,
    input  logic [15:0] y_i,
    input  logic        zx_i,
    input  logic        nx_i,
    input  logic        zy_i,
    input  logic        ny_i,
    input  logic        f_i,
    input  logic        no_i,
    output logic [15:0] out_o,
    output logic        zr_o,
    output logic        ng_o
);

    logic [15:0] x_z;
    logic [15:0] x_n;
    logic [15:0] y_z;
    logic [15:0] y_n;
    logic [15:0] f_out;

    always_comb begin
        x_z   = zx_i ? '0 : x_i;
        x_n   = nx_i ? ~x_z : x_z;
        y_z   = zy_i ? '0 : y_i;
        y_n   = ny_i ? ~y_z : y_z;
        f_out = f_i ? (x_n + y_n) : (x_n & y_n);
        out_o = no_i ? ~f_out : f_out;
    end

    assign zr_o = (out_o == '0);
    assign ng_o = out_o[15];

endmodule

// File: rtl/alu_mul_seq.sv
// Shift-and-add multiplier producing (a*b) mod 2^16; every addition, including
// the multiplicand doubling, is routed through one shared Hack ALU.
module alu_mul_seq
    import hack_alu_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] product,
    output logic             zr,
    output logic             ng,
    output logic             busy
);

    localparam logic [5:0] ALU_CTRL = ALU_X_PLUS_Y;

    mul_state_e       state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mc_q, mc_d;
    logic [WIDTH-1:0] mp_q, mp_d;
    logic [4:0]       cnt_q, cnt_d;

    logic [15:0] alu_x;
    logic [15:0] alu_out;
    logic        alu_zr_unused;
    logic        alu_ng_unused;

    // ADD accumulates the multiplicand; every other state doubles it (mc+mc).
    assign alu_x = (state_q == S_ADD) ? acc_q : mc_q;

    hack_alu u_alu (
        .x_i   (alu_x),
        .y_i   (mc_q),
        .zx_i  (ALU_CTRL[5]),
        .nx_i  (ALU_CTRL[4]),
        .zy_i  (ALU_CTRL[3]),
        .ny_i  (ALU_CTRL[2]),
        .f_i   (ALU_CTRL[1]),
        .no_i  (ALU_CTRL[0]),
        .out_o (alu_out),
        .zr_o  (alu_zr_unused),
        .ng_o  (alu_ng_unused)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            mc_q    <= '0;
            mp_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            mc_q    <= mc_d;
            mp_q    <= mp_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        mc_d    = mc_q;
        mp_d    = mp_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    acc_d   = '0;
                    mc_d    = a;
                    mp_d    = b;
                    cnt_d   = '0;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (EARLY_EXIT && (mp_q == '0)) begin
                    state_d = S_DONE;
                end else if (!EARLY_EXIT && (cnt_q == 5'(WIDTH))) begin
                    state_d = S_DONE;
                end else if (mp_q[0]) begin
                    state_d = S_ADD;
                end else begin
                    state_d = S_DBL;
                end
            end
            S_ADD: begin
                acc_d   = alu_out;
                state_d = S_DBL;
            end
            S_DBL: begin
                mc_d    = alu_out;
                mp_d    = mp_q >> 1;
                cnt_d   = cnt_q + 5'd1;
                state_d = S_CHECK;
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Result outputs are forced to zero outside DONE so reset values hold.
    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q == S_CHECK) || (state_q == S_ADD) || (state_q == S_DBL);
    assign product   = out_valid ? acc_q : '0;
    assign zr        = out_valid && (acc_q == '0);
    assign ng        = out_valid && acc_q[WIDTH-1];

endmodule

// File: tb/tb_alu_mul_seq.sv
// Scoreboard bench: one instance per EARLY_EXIT setting, shared stimulus,
// per-instance queues of expected product and latency.
module tb_alu_mul_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        out_ready;
    logic [15:0] a_s;
    logic [15:0] b_s;
    logic [1:0]  in_ready;
    logic [1:0]  out_valid;
    logic [1:0]  zr;
    logic [1:0]  ng;
    logic [1:0]  busy;
    logic [15:0] product [2];

    int n_vec = 0;
    int n_mis = 0;
    int cyc   = 0;

    typedef struct {
        logic [15:0] prod;
        int          lat;
        int          acc_edge;
    } exp_t;

    exp_t sb_q [2][$];
    logic [1:0] prev_ov;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        alu_mul_seq #(.WIDTH(16), .EARLY_EXIT(g == 0)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid),
            .in_ready  (in_ready[g]),
            .a         (a_s),
            .b         (b_s),
            .out_valid (out_valid[g]),
            .out_ready (out_ready),
            .product   (product[g]),
            .zr        (zr[g]),
            .ng        (ng[g]),
            .busy      (busy[g])
        );
    end

    function automatic void ref_model(input logic [15:0] av, input logic [15:0] bv,
                                      input bit ee, output logic [15:0] p, output int lat);
        longint unsigned full;
        int hi;
        full = longint'(av) * longint'(bv);
        p    = full[15:0];
        hi   = 0;
        for (int k = 0; k < 16; k++) if (bv[k]) hi = k + 1;
        lat = ee ? (1 + 2 * hi + $countones(bv)) : (1 + 32 + $countones(bv));
    endfunction

    task automatic check(input string nm, input int inst, input logic [31:0] act,
                         input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s[%0d]: got 0x%0h, expected 0x%0h (t=%0t)", nm, inst, act, exp, $time);
        end
    endtask

    task automatic timeout(input string nm);
        n_vec++;
        n_mis++;
        $display("FAIL %s: wait bound expired (t=%0t)", nm, $time);
    endtask

    // Monitor: push on accept, check latency on out_valid rise, pop on handshake.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb_q[0].delete();
            sb_q[1].delete();
            prev_ov = '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (in_valid && in_ready[i]) begin
                    exp_t e;
                    ref_model(a_s, b_s, (i == 0), e.prod, e.lat);
                    e.acc_edge = cyc + 1;
                    sb_q[i].push_back(e);
                end
                if (out_valid[i] && !prev_ov[i]) begin
                    if (sb_q[i].size() == 0) timeout("unexpected_out_valid");
                    else check("latency", i, 32'(cyc - sb_q[i][0].acc_edge), 32'(sb_q[i][0].lat));
                end
                if (out_valid[i] && out_ready) begin
                    if (sb_q[i].size() == 0) begin
                        timeout("unexpected_result");
                    end else begin
                        exp_t e;
                        e = sb_q[i].pop_front();
                        check("product", i, 32'(product[i]), 32'(e.prod));
                        check("zr", i, 32'(zr[i]), 32'(e.prod == 16'h0));
                        check("ng", i, 32'(ng[i]), 32'(e.prod[15]));
                    end
                end
                prev_ov[i] = out_valid[i];
            end
        end
    end

    task automatic check_reset(input string nm);
        for (int i = 0; i < 2; i++) begin
            check({nm, "_in_ready"}, i, 32'(in_ready[i]), 32'd1);
            check({nm, "_out_valid"}, i, 32'(out_valid[i]), 32'd0);
            check({nm, "_busy"}, i, 32'(busy[i]), 32'd0);
            check({nm, "_product"}, i, 32'(product[i]), 32'd0);
            check({nm, "_zr"}, i, 32'(zr[i]), 32'd0);
            check({nm, "_ng"}, i, 32'(ng[i]), 32'd0);
        end
    endtask

    task automatic issue(input logic [15:0] av, input logic [15:0] bv);
        int t = 0;
        while (!(in_ready[0] && in_ready[1]) && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 200) timeout("issue_wait_ready");
        a_s      = av;
        b_s      = bv;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain(input bit rnd);
        int t = 0;
        while (!(sb_q[0].size() == 0 && sb_q[1].size() == 0 && out_valid == 2'b00) && t < 400) begin
            out_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            @(posedge clk); #1;
            t++;
        end
        if (t >= 400) timeout("drain");
        out_ready = 1'b1;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] ep;
        int          el;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a_s       = '0;
        b_s       = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset("por");
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_reset("idle");

        out_ready = 1'b1;
        issue(16'd3, 16'd5);           drain(1'b0);
        issue(16'h1234, 16'h0000);     drain(1'b0);
        issue(16'h0100, 16'h0100);     drain(1'b0);
        issue(16'hFFFD, 16'd7);        drain(1'b0);
        issue(16'hFFFF, 16'hFFFF);     drain(1'b0);
        issue(16'h0000, 16'hBEEF);     drain(1'b0);

        // Backpressure: result must hold; in_valid pulse must be ignored.
        out_ready = 1'b0;
        issue(16'hFFFD, 16'd7);
        begin
            int t = 0;
            while (out_valid != 2'b11 && t < 100) begin
                @(posedge clk); #1;
                t++;
            end
            if (t >= 100) timeout("wait_done");
        end
        ref_model(16'hFFFD, 16'd7, 1'b1, ep, el);
        for (int c = 0; c < 10; c++) begin
            for (int i = 0; i < 2; i++) begin
                check("hold_valid", i, 32'(out_valid[i]), 32'd1);
                check("hold_product", i, 32'(product[i]), 32'(ep));
                check("hold_zr", i, 32'(zr[i]), 32'd0);
                check("hold_ng", i, 32'(ng[i]), 32'd1);
                check("hold_in_ready", i, 32'(in_ready[i]), 32'd0);
            end
            in_valid = (c == 3);
            a_s      = 16'd5;
            b_s      = 16'd5;
            @(posedge clk); #1;
        end
        in_valid  = 1'b1;
        out_ready = 1'b1;
        a_s       = 16'd2;
        b_s       = 16'd3;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check("retire_no_bypass_busy", i, 32'(busy[i]), 32'd0);
            check("retire_in_ready", i, 32'(in_ready[i]), 32'd1);
        end
        repeat (60) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) check("no_phantom", i, 32'(out_valid[i]), 32'd0);
        out_ready = 1'b1;
        issue(16'd5, 16'd5);           drain(1'b0);

        // Asynchronous reset during the first ADD of 7*9.
        issue(16'd7, 16'd9);
        @(posedge clk); #2;
        for (int i = 0; i < 2; i++) check("pre_reset_busy", i, 32'(busy[i]), 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset("async");
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_reset("post");
        issue(16'd2, 16'd2);           drain(1'b0);

        for (int v = 0; v < 1000; v++) begin
            logic [15:0] av;
            logic [15:0] bv;
            av = 16'($urandom);
            bv = 16'($urandom);
            case ($urandom_range(0, 3))
                0: bv = bv >> $urandom_range(0, 15);
                1: av = av >> $urandom_range(0, 15);
                default: ;
            endcase
            issue(av, bv);
            drain(1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
